audio_serial_port: RTL

//  Parametrised serial audio transceiver with internal bit and frame clock generation.

---
 rtl/audio_pkg.sv | 19 +
 rtl/audio_frame_timer.sv | 67 ++++++
 rtl/audio_serial_port.sv | 134 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the serial audio port: format codes and frame/channel geometry helpers.
package audio_pkg;

  localparam logic FMT_I2S = 1'b0;
  localparam logic FMT_LJ  = 1'b1;

  // Number of SCLK periods in one full frame.
  function automatic int unsigned frame_bits(input int unsigned channels,
                                             input int unsigned slot_bits);
    return channels * slot_bits;
  endfunction

  // LSB index of a channel field inside the packed tx_data / rx_data vectors.
  function automatic int unsigned chan_lsb(input int unsigned ch,
                                           input int unsigned resolution);
    return ch * resolution;
  endfunction

endpackage

// File: rtl/audio_frame_timer.sv
// Bit/frame clock generator: divider, bit index, SCLK and the wrap/falling/rising strobes.
module audio_frame_timer
  import audio_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned SCLK_DIV  = 8,
  localparam int unsigned FRAME    = frame_bits(CHANNELS, SLOT_BITS),
  localparam int unsigned B_W      = $clog2(FRAME)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  output logic [B_W-1:0] bit_idx,
  output logic [B_W-1:0] bit_idx_next_c,
  output logic           wrap_c,
  output logic           fall_c,
  output logic           rise_c,
  output logic           sclk_out
);

  localparam int unsigned D_W     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned HALF    = SCLK_DIV / 2;
  localparam int unsigned DIV_MAX = SCLK_DIV - 1;
  localparam int unsigned B_MAX   = FRAME - 1;

  logic [D_W-1:0] div_cnt;
  logic [D_W-1:0] div_next;

  // Idle parks the counters on the last bit so the first enabled cycle is a wrap.
  always_comb begin
    div_next       = div_cnt;
    bit_idx_next_c = bit_idx;
    wrap_c         = 1'b0;
    fall_c         = 1'b0;
    rise_c         = 1'b0;
    if (!enable) begin
      div_next       = D_W'(DIV_MAX);
      bit_idx_next_c = B_W'(B_MAX);
    end else if (div_cnt == D_W'(DIV_MAX)) begin
      div_next = '0;
      fall_c   = 1'b1;
      if (bit_idx == B_W'(B_MAX)) begin
        bit_idx_next_c = '0;
        wrap_c         = 1'b1;
      end else begin
        bit_idx_next_c = bit_idx + B_W'(1);
      end
    end else begin
      div_next = div_cnt + D_W'(1);
      rise_c   = (div_cnt == D_W'(HALF - 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= D_W'(DIV_MAX);
      bit_idx  <= B_W'(B_MAX);
      sclk_out <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      bit_idx  <= bit_idx_next_c;
      sclk_out <= enable && (div_next >= D_W'(HALF));
    end
  end

endmodule

// File: rtl/audio_serial_port.sv
// Serial audio transceiver (I2S / left-justified, stereo LRCK or TDM frame sync) with internal clocking.
module audio_serial_port
  import audio_pkg::*;
#(
  parameter int unsigned RESOLUTION = 24,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned SLOT_BITS  = 32,
  parameter int unsigned SCLK_DIV   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           mode,
  input  logic                           sdata_in,
  input  logic [CHANNELS*RESOLUTION-1:0] tx_data,
  output logic                           tx_req,
  output logic [CHANNELS*RESOLUTION-1:0] rx_data,
  output logic                           rx_valid,
  output logic                           sclk_out,
  output logic                           lrck_out,
  output logic                           sdata_out
);

  localparam int unsigned FRAME = frame_bits(CHANNELS, SLOT_BITS);
  localparam int unsigned B_W   = $clog2(FRAME);
  localparam int unsigned W     = CHANNELS * RESOLUTION;
  localparam int unsigned W_IDX = $clog2(W);

  logic [B_W-1:0] bit_idx;
  logic [B_W-1:0] bit_idx_next;
  logic           wrap_c;
  logic           fall_c;
  logic           rise_c;

  audio_frame_timer #(
    .CHANNELS (CHANNELS),
    .SLOT_BITS(SLOT_BITS),
    .SCLK_DIV (SCLK_DIV)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .bit_idx       (bit_idx),
    .bit_idx_next_c(bit_idx_next),
    .wrap_c        (wrap_c),
    .fall_c        (fall_c),
    .rise_c        (rise_c),
    .sclk_out      (sclk_out)
  );

  logic         dly;
  logic         dly_next;
  logic [W-1:0] shadow;
  logic [W-1:0] shadow_next;
  logic [W-1:0] rx_shift;
  logic         rx_pend;

  int unsigned  tx_d, tx_slot, tx_pos;
  int unsigned  rx_d, rx_slot, rx_pos;
  logic         tx_bit_c;
  logic         lrck_c;
  logic         rx_take_c;
  logic         rx_last_c;

  // Position of bit index b inside the data stream after the format delay.
  function automatic int unsigned data_pos(input logic [B_W-1:0] b, input logic delay);
    return (32'(b) + FRAME - 32'(delay)) % FRAME;
  endfunction

  // TX decode looks at the post-edge bit index so outputs change as SCLK falls.
  always_comb begin
    dly_next    = dly;
    shadow_next = shadow;
    if (wrap_c) begin
      dly_next    = (mode == FMT_I2S);
      shadow_next = tx_data;
    end
    tx_d     = data_pos(bit_idx_next, dly_next);
    tx_slot  = tx_d / SLOT_BITS;
    tx_pos   = tx_d % SLOT_BITS;
    tx_bit_c = 1'b0;
    if (tx_pos < RESOLUTION)
      tx_bit_c = shadow_next[W_IDX'(chan_lsb(tx_slot, RESOLUTION) + RESOLUTION - 1 - tx_pos)];
    lrck_c = (CHANNELS == 2) ? (32'(bit_idx_next) >= SLOT_BITS) : (bit_idx_next == '0);
  end

  // RX decode uses the current bit index: the sample edge sits mid-bit.
  always_comb begin
    rx_d      = data_pos(bit_idx, dly);
    rx_slot   = rx_d / SLOT_BITS;
    rx_pos    = rx_d % SLOT_BITS;
    rx_take_c = rise_c && (rx_pos < RESOLUTION);
    rx_last_c = rise_c && (rx_slot == CHANNELS - 1) && (rx_pos == RESOLUTION - 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly       <= 1'b0;
      shadow    <= '0;
      rx_shift  <= '0;
      rx_pend   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      lrck_out  <= 1'b0;
      sdata_out <= 1'b0;
    end else begin
      dly    <= dly_next;
      shadow <= shadow_next;
      tx_req <= wrap_c;
      if (!enable) begin
        rx_shift  <= '0;
        rx_pend   <= 1'b0;
        rx_valid  <= 1'b0;
        lrck_out  <= 1'b0;
        sdata_out <= 1'b0;
      end else begin
        if (fall_c) begin
          sdata_out <= tx_bit_c;
          lrck_out  <= lrck_c;
        end
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
          if (rx_take_c && (rx_slot == ch))
            rx_shift[chan_lsb(ch, RESOLUTION) +: RESOLUTION] <=
              {rx_shift[chan_lsb(ch, RESOLUTION) +: RESOLUTION-1], sdata_in};
        end
        rx_pend  <= rx_last_c;
        rx_valid <= rx_pend;
        if (rx_pend) rx_data <= rx_shift;
      end
    end
  end

endmodule
